fios_ctrl_ring: RTL and testbench
=================================

// Module: fios_ctrl_ring
// PURPOSE
//  Parametrised control-distribution ring for FIOS Montgomery multipliers. Feeds per-PE control words.
//  Takes a seed control word from the FIOS control FSM and delays it PE_DELAY cycles per PE.
//  In FOLD mode it closes the loop from the last PE back to PE0. Generates gated output strobes.
//  Adds a start/ready handshake with one queued start, a flushing reset and an overflow flag.
//  Sits between fios_control_* and the FIOS_MM datapath.
// PARAMETERS
//  CONFIGURATION  "FOLD"  "FOLD" = ring with loop-back; "EXPAND" = open chain, PE_NB==s
//  s              8       operand words per multiplication
//  PE_NB          3       processing elements (must be 1..s)
//  CTRL_W         24      control word width (low 4 bits fixed fields, see package)
//  PE_DELAY       8       cycles between adjacent PEs
//  LOOP_DELAY     0       extra loop-back cycles (FOLD only)
// PORTS
//  clock_i      in   1              clock
//  reset_i      in   1              synchronous, active-high reset
//  start_i      in   1              request a multiplication
//  ready_o      out  1              1 = no run active, start_i accepted immediately
//  pending_o    out  1              a start is queued behind the current run
//  overflow_o   out  1              sticky: a start was dropped
//  fsm_start_o  out  1              one-cycle start pulse to the control FSM
//  seed_ctrl_i  in   CTRL_W         control word from the FSM (PE0 source, first pass)
//  pe_ctrl_o    out  PE_NB*CTRL_W   control word of PE i at [i*CTRL_W +: CTRL_W]
//  input_sel_o  out  1              datapath loop-back select (1 = PE0 fed by last PE)
//  a_shift_o    out  1              registered a_shift of PE PE_NB-1
//  res_push_o   out  1              result word valid
//  done_o       out  1              one-cycle end-of-multiplication
//  pass_cnt_o   out  clog2(s/PE_NB+1)  completed ring passes
// BEHAVIOUR
//  Control word fields: [0] done, [1] start, [2] res_push, [3] a_shift. The other bits pass through untouched.
//  Reset values:
//   - ready_o=1; fsm_start_o, pending_o, overflow_o, input_sel_o, a_shift_o, res_push_o, done_o = 0.
//   - pass_cnt_o=0.
//   - All delay stages are flushed to 0, so reset mid-run leaves no stale control in flight.
//  FSM IDLE/RUN:
//   - IDLE + start_i at cycle T -> RUN; fsm_start_o=1 at T+1.
//   - RUN + start_i with pending_o=0 -> pending_o=1.
//   - RUN + start_i with pending_o=1 -> start dropped, overflow_o=1. Only reset clears overflow_o.
//   - done_o with pending_o=1 -> pending_o=0; fsm_start_o=1 next cycle; stay RUN. Otherwise -> IDLE.
//   - start_i in the same cycle as done_o counts as a RUN-state start.
//  Ring:
//   - Stage k+1 = stage k delayed PE_DELAY cycles.
//   - In FOLD, the start bit loops back from PE_NB-1 to PE0 after PE_DELAY+1+LOOP_DELAY cycles.
//   - PE0 source = seed_ctrl_i while input_sel_o=0, else the looped-back word.
//   - input_sel_o sets the cycle after done bit is seen at PE0 (FOLD only); clears on done_o. EXPAND: always 0.
//  Output gating:
//   - pass_cnt increments on a_shift at PE_NB-1 while output_en=0.
//   - output_en sets when pass_cnt==(s-1)/PE_NB and a_shift at PE (s-1)%PE_NB.
//   - res_push_o/done_o = bits of PE (s-1)%PE_NB registered 1 cycle, ANDed with output_en. EXPAND: output_en=1.
//   - done_o clears output_en and pass_cnt on the next cycle.
// CONFIGURATION
//  FIOS_CYCLE_COUNT_EN defined:
//   - Adds port cycles_o out 32. The counter clears on the cycle a start is launched and increments each cycle.
//   - cycles_o latches the counter value at done_o and saturates at 2^32-1.
//  FIOS_CYCLE_COUNT_EN undefined: no port, no counter logic.
// STRUCTURE
//  fios_ctrl_pkg:
//   - CTRL_DONE/START/PUSH/ASHIFT bit indices and config_e {FOLD, EXPAND}.
//   - function pe_delay(dsp_reg_level): 1->5, 2->6, 3->8.
//  Sub-module fios_ctrl_stage: CTRL_W-wide, DELAY-deep shift register with synchronous reset.
//  The ring instantiates PE_NB-1 inter-PE stages plus, in FOLD, one 1-bit loop-back stage.
// TESTING
//  - EXPAND, s=PE_NB=8, PE_DELAY=8: seed 0xA5A5A0 at cycle 10 -> pe_ctrl_o[PE3] = 0xA5A5A0 at cycle 34.
//  - FOLD, s=8, PE_NB=3: first res_push_o only after pass_cnt_o==2 with a_shift at PE1; no res_push_o before.
//  - start_i in IDLE at T -> ready_o=0 at T+1, fsm_start_o pulse at T+1; second start in RUN -> pending_o=1.
//    At done_o, a new fsm_start_o follows 1 cycle later.
//  - Three starts during one run -> third dropped, overflow_o=1 until reset_i.
//  - reset_i mid-run, then a fresh start -> all pe_ctrl_o=0 during flush; the new run matches the golden trace.
//  - FIOS_CYCLE_COUNT_EN, FOLD s=8 PE_NB=3: cycles_o equals the measured start-to-done distance; a second run gives the same value.

Source files
------------

// File: rtl/fios_ctrl_pkg.sv
// fios_ctrl_pkg
//   Shared definitions for the FIOS control-distribution ring.
//   - CTRL_* : bit positions of the fixed fields in a control word.
//   - config_e : ring topology (FOLD = loop-back ring, EXPAND = open chain).
//   - state_e : start/run handshake FSM states.
//   - pe_delay() : inter-PE latency for a given number of DSP register levels.
package fios_ctrl_pkg;

   localparam int CTRL_DONE   = 0;
   localparam int CTRL_START  = 1;
   localparam int CTRL_PUSH   = 2;
   localparam int CTRL_ASHIFT = 3;

   typedef enum logic {
      FOLD   = 1'b0,
      EXPAND = 1'b1
   } config_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Pipeline depth of one PE as a function of its DSP register levels.
   function automatic int pe_delay(input int dsp_reg_level);
      case (dsp_reg_level)
         1:       return 5;
         2:       return 6;
         default: return 8;
      endcase
   endfunction

endpackage

// File: rtl/fios_ctrl_stage.sv
// fios_ctrl_stage
//   W-bit wide, DELAY-deep shift register. A synchronous reset clears every
//   entry so nothing stale survives a reset.
// Ports:
//   clock_i  in   1   clock
//   reset_i  in   1   synchronous active-high reset
//   d_i      in   W   word entering the delay line
//   q_o      out  W   d_i delayed by DELAY cycles
module fios_ctrl_stage #(
   parameter int W     = 24,
   parameter int DELAY = 8
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sr_q [DELAY];

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < DELAY; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DELAY; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[DELAY-1];

endmodule

// File: rtl/fios_ctrl_ring.sv
// fios_ctrl_ring
//   Distributes the FIOS control word to PE_NB processing elements, each PE
//   seeing the word PE_DELAY cycles after its predecessor. In FOLD the start
//   bit of the last PE is looped back into PE0; outputs are gated until the
//   last operand word reaches its PE. A start/ready handshake with one queued
//   start and a sticky overflow flag launches the control FSM.
//   Optional macro FIOS_CYCLE_COUNT_EN adds a 32-bit start-to-done cycle count.
// Ports:
//   clock_i, reset_i    clock, synchronous active-high reset
//   start_i / ready_o   start request / no run active
//   pending_o           a start is queued behind the current run
//   overflow_o          sticky, a start was dropped
//   fsm_start_o         one-cycle launch pulse to the control FSM
//   seed_ctrl_i         control word from the FSM (PE0 source)
//   pe_ctrl_o           per-PE control words, PE i at [i*CTRL_W +: CTRL_W]
//   input_sel_o         1 = PE0 fed from the last PE
//   a_shift_o           registered a_shift of the last PE
//   res_push_o, done_o  gated result-valid and end-of-multiplication
//   state_o             handshake FSM state
//   pass_cnt_o          completed ring passes
//   cycles_o            (FIOS_CYCLE_COUNT_EN) start-to-done cycle count
module fios_ctrl_ring
   import fios_ctrl_pkg::*;
#(
   parameter config_e CONFIGURATION = FOLD,
   parameter int      s             = 8,
   parameter int      PE_NB         = 3,
   parameter int      CTRL_W        = 24,
   parameter int      PE_DELAY      = pe_delay(3),
   parameter int      LOOP_DELAY    = 0,
   localparam int     PC_W          = $clog2(s / PE_NB + 1)
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   output logic                    ready_o,
   output logic                    pending_o,
   output logic                    overflow_o,
   output logic                    fsm_start_o,
   input  logic [CTRL_W-1:0]       seed_ctrl_i,
   output logic [PE_NB*CTRL_W-1:0] pe_ctrl_o,
   output logic                    input_sel_o,
   output logic                    a_shift_o,
   output logic                    res_push_o,
   output logic                    done_o,
   output state_e                  state_o,
   output logic [PC_W-1:0]         pass_cnt_o
`ifdef FIOS_CYCLE_COUNT_EN
   ,output logic [31:0]            cycles_o
`endif
);

   localparam bit IS_FOLD   = (CONFIGURATION == FOLD);
   localparam int LAST      = PE_NB - 1;
   localparam int TAP       = (s - 1) % PE_NB;   // PE holding the last operand word
   localparam int LAST_PASS = (s - 1) / PE_NB;   // pass in which that word is processed

   state_e            state_q, state_d;
   logic              pending_q, pending_d, pend_eff;
   logic              overflow_q, overflow_d;
   logic              fsm_start_q, fsm_start_d;
   logic              input_sel_q, input_sel_d;
   logic              output_en_q, output_en_d, output_en_w;
   logic [PC_W-1:0]   pass_cnt_q, pass_cnt_d;
   logic              ashift_q, push_tap_q, done_tap_q;

   logic [PE_NB-1:0][CTRL_W-1:0] pe_w;
   logic [CTRL_W-1:0]            pe0_w;
   logic                         loop_start_w;

   // ---------------- ring ----------------
   // Only the start bit travels around the loop; the remaining fields keep
   // coming from the control FSM.
   always_comb begin
      pe0_w = seed_ctrl_i;
      if (input_sel_q) pe0_w[CTRL_START] = loop_start_w;
   end
   assign pe_w[0] = pe0_w;

   for (genvar i = 1; i < PE_NB; i++) begin : g_pe
      fios_ctrl_stage #(.W(CTRL_W), .DELAY(PE_DELAY)) u_stage (
         .clock_i (clock_i),
         .reset_i (reset_i),
         .d_i     (pe_w[i-1]),
         .q_o     (pe_w[i])
      );
   end

   if (IS_FOLD) begin : g_loop
      fios_ctrl_stage #(.W(1), .DELAY(PE_DELAY + 1 + LOOP_DELAY)) u_loop (
         .clock_i (clock_i),
         .reset_i (reset_i),
         .d_i     (pe_w[LAST][CTRL_START]),
         .q_o     (loop_start_w)
      );
   end else begin : g_open
      assign loop_start_w = 1'b0;
   end

   assign pe_ctrl_o = pe_w;

   // ---------------- output gating ----------------
   assign output_en_w = IS_FOLD ? output_en_q : 1'b1;
   assign res_push_o  = push_tap_q & output_en_w;
   assign done_o      = done_tap_q & output_en_w;

   always_comb begin
      pass_cnt_d  = pass_cnt_q;
      output_en_d = output_en_q;
      input_sel_d = input_sel_q;
      if (done_o) begin
         pass_cnt_d  = '0;
         output_en_d = 1'b0;
         input_sel_d = 1'b0;
      end else begin
         if (!output_en_w && pe_w[LAST][CTRL_ASHIFT]) pass_cnt_d = pass_cnt_q + 1'b1;
         if ((pass_cnt_q == PC_W'(LAST_PASS)) && pe_w[TAP][CTRL_ASHIFT]) output_en_d = 1'b1;
         if (pe_w[0][CTRL_DONE]) input_sel_d = 1'b1;
      end
      if (!IS_FOLD) begin
         output_en_d = 1'b0;
         input_sel_d = 1'b0;
      end
   end

   // ---------------- handshake FSM ----------------
   // start_i/ready_o: ready_o=1 means IDLE and a start launches on the next
   // cycle. During RUN one start is queued (pending_o); a further start is
   // dropped and sets overflow_o. A start coinciding with done_o is a RUN start.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      overflow_d  = overflow_q;
      fsm_start_d = 1'b0;
      pend_eff    = pending_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d     = ST_RUN;
               fsm_start_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (start_i) begin
               if (pending_q) overflow_d = 1'b1;
               else           pend_eff   = 1'b1;
            end
            if (done_o) begin
               pending_d = 1'b0;
               if (pend_eff) fsm_start_d = 1'b1;
               else          state_d     = ST_IDLE;
            end else begin
               pending_d = pend_eff;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         pending_q   <= 1'b0;
         overflow_q  <= 1'b0;
         fsm_start_q <= 1'b0;
         input_sel_q <= 1'b0;
         output_en_q <= 1'b0;
         pass_cnt_q  <= '0;
         ashift_q    <= 1'b0;
         push_tap_q  <= 1'b0;
         done_tap_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
         fsm_start_q <= fsm_start_d;
         input_sel_q <= input_sel_d;
         output_en_q <= output_en_d;
         pass_cnt_q  <= pass_cnt_d;
         ashift_q    <= pe_w[LAST][CTRL_ASHIFT];
         push_tap_q  <= pe_w[TAP][CTRL_PUSH];
         done_tap_q  <= pe_w[TAP][CTRL_DONE];
      end
   end

   assign ready_o     = (state_q == ST_IDLE);
   assign pending_o   = pending_q;
   assign overflow_o  = overflow_q;
   assign fsm_start_o = fsm_start_q;
   assign input_sel_o = input_sel_q;
   assign a_shift_o   = ashift_q;
   assign state_o     = state_q;
   assign pass_cnt_o  = pass_cnt_q;

`ifdef FIOS_CYCLE_COUNT_EN
   // Counter is zero in the cycle fsm_start_o is high; done_o latches it.
   logic [31:0] cnt_q, cnt_d, cycles_q, cycles_d;

   always_comb begin
      cnt_d    = fsm_start_d ? 32'd0 : ((&cnt_q) ? cnt_q : cnt_q + 32'd1);
      cycles_d = done_o ? cnt_q : cycles_q;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q    <= '0;
         cycles_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         cycles_q <= cycles_d;
      end
   end

   assign cycles_o = cycles_q;
`else
   // Cycle counter not built.
`endif

endmodule

// File: tb/tb_fios_ctrl_ring.sv
module tb_fios_ctrl_ring;
   import fios_ctrl_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;

   // ---------------- FOLD instance: s=8, PE_NB=3 ----------------
   logic        f_start = 1'b0;
   logic [23:0] f_seed  = '0;
   logic        f_ready, f_pending, f_overflow, f_fsm_start;
   logic        f_input_sel, f_a_shift, f_res_push, f_done;
   logic [71:0] f_pe;
   logic [1:0]  f_pass;
   state_e      f_state;

   // ---------------- EXPAND instance: s=PE_NB=8 ----------------
   logic         e_start = 1'b0;
   logic [23:0]  e_seed  = '0;
   logic         e_ready, e_pending, e_overflow, e_fsm_start;
   logic         e_input_sel, e_a_shift, e_res_push, e_done;
   logic [191:0] e_pe;
   logic [0:0]   e_pass;
   state_e       e_state;

`ifdef FIOS_CYCLE_COUNT_EN
   logic [31:0] f_cycles, e_cycles;
`endif

   fios_ctrl_ring #(
      .CONFIGURATION(FOLD), .s(8), .PE_NB(3), .CTRL_W(24), .PE_DELAY(8), .LOOP_DELAY(0)
   ) u_fold (
      .clock_i(clk), .reset_i(rst), .start_i(f_start), .ready_o(f_ready),
      .pending_o(f_pending), .overflow_o(f_overflow), .fsm_start_o(f_fsm_start),
      .seed_ctrl_i(f_seed), .pe_ctrl_o(f_pe), .input_sel_o(f_input_sel),
      .a_shift_o(f_a_shift), .res_push_o(f_res_push), .done_o(f_done),
      .state_o(f_state), .pass_cnt_o(f_pass)
`ifdef FIOS_CYCLE_COUNT_EN
      , .cycles_o(f_cycles)
`endif
   );

   fios_ctrl_ring #(
      .CONFIGURATION(EXPAND), .s(8), .PE_NB(8), .CTRL_W(24), .PE_DELAY(8), .LOOP_DELAY(0)
   ) u_expand (
      .clock_i(clk), .reset_i(rst), .start_i(e_start), .ready_o(e_ready),
      .pending_o(e_pending), .overflow_o(e_overflow), .fsm_start_o(e_fsm_start),
      .seed_ctrl_i(e_seed), .pe_ctrl_o(e_pe), .input_sel_o(e_input_sel),
      .a_shift_o(e_a_shift), .res_push_o(e_res_push), .done_o(e_done),
      .state_o(e_state), .pass_cnt_o(e_pass)
`ifdef FIOS_CYCLE_COUNT_EN
      , .cycles_o(e_cycles)
`endif
   );

   // ---------------- scoreboard ----------------
   int          n_chk = 0;
   int          n_bad = 0;
   logic [23:0] exp_q[$];

   task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // EXPAND: pure delay chain, outputs never gated.
   task automatic expand_run();
      logic [23:0] seed;
      for (int k = 0; k < 61; k++) begin
         @(posedge clk); #1;
         case (k)
            1:       seed = 24'h000005;   // done + res_push
            10:      seed = 24'hA5A5A0;
            default: seed = 24'h000000;
         endcase
         e_seed = seed;
         exp_q.push_back(seed);
         @(negedge clk);
         if (k >= 24) chk("e_pe3_trace", 192'(e_pe[72 +: 24]), 192'(exp_q.pop_front()));
         case (k)
            2:  chk("e_input_sel", 192'(e_input_sel), 192'(0));
            10: chk("e_pe0", 192'(e_pe[0 +: 24]), 192'(24'hA5A5A0));
            17: chk("e_pe1_early", 192'(e_pe[24 +: 24]), 192'(0));
            18: chk("e_pe1", 192'(e_pe[24 +: 24]), 192'(24'hA5A5A0));
            34: chk("e_pe3", 192'(e_pe[72 +: 24]), 192'(24'hA5A5A0));
            57: begin
               chk("e_pe7", 192'(e_pe[168 +: 24]), 192'(24'h000005));
               chk("e_done_early", 192'(e_done), 192'(0));
            end
            58: begin
               chk("e_done", 192'(e_done), 192'(1));
               chk("e_res_push", 192'(e_res_push), 192'(1));
               chk("e_ready", 192'(e_ready), 192'(1));
               chk("e_pass", 192'(e_pass), 192'(0));
            end
            59: chk("e_done_pulse", 192'(e_done), 192'(0));
            default: ;
         endcase
      end
      e_seed = '0;
   endtask

   // FOLD: three starts, three a_shift passes, push/done, loop-back of a start
   // bit, then a reset in the middle of the queued second run.
   task automatic fold_run();
      int   t_start, t_done;
      logic early_push;
      t_start    = -1;
      t_done     = -1;
      early_push = 1'b0;
      for (int k = 0; k < 90; k++) begin
         @(posedge clk); #1;
         f_start = (k == 0) || (k == 5) || (k == 7);
         rst     = (k == 72);
         case (k)
            2:       f_seed = 24'h000008;
            27:      f_seed = 24'h00000C;
            30:      f_seed = 24'h000002;
            52:      f_seed = 24'h00000C;
            54:      f_seed = 24'h000005;
            70:      f_seed = 24'hFF0008;
            default: f_seed = 24'h000000;
         endcase
         @(negedge clk);
         if (f_fsm_start && t_start < 0) t_start = k;
         if (f_done && t_done < 0) t_done = k;
         if (k < 61 && f_res_push) early_push = 1'b1;
         case (k)
            0: begin
               chk("f_ready_idle", 192'(f_ready), 192'(1));
               chk("f_fsm_start0", 192'(f_fsm_start), 192'(0));
            end
            1: begin
               chk("f_ready_run", 192'(f_ready), 192'(0));
               chk("f_fsm_start", 192'(f_fsm_start), 192'(1));
               chk("f_state_run", 192'(f_state), 192'(ST_RUN));
            end
            2:  chk("f_fsm_start_pulse", 192'(f_fsm_start), 192'(0));
            6: begin
               chk("f_pending", 192'(f_pending), 192'(1));
               chk("f_overflow0", 192'(f_overflow), 192'(0));
            end
            8: begin
               chk("f_overflow", 192'(f_overflow), 192'(1));
               chk("f_pending_kept", 192'(f_pending), 192'(1));
            end
            18: chk("f_a_shift0", 192'(f_a_shift), 192'(0));
            19: begin
               chk("f_a_shift", 192'(f_a_shift), 192'(1));
               chk("f_pass1", 192'(f_pass), 192'(1));
            end
            36: begin
               chk("f_push_gated", 192'(f_res_push), 192'(0));
               chk("f_pass1_hold", 192'(f_pass), 192'(1));
            end
            44: chk("f_pass2", 192'(f_pass), 192'(2));
            54: begin
               chk("f_input_sel0", 192'(f_input_sel), 192'(0));
               chk("f_pe0_seed", 192'(f_pe[0 +: 24]), 192'(24'h000005));
            end
            55: begin
               chk("f_input_sel", 192'(f_input_sel), 192'(1));
               chk("f_pe0_loop", 192'(f_pe[0 +: 24]), 192'(24'h000002));
            end
            60: begin
               chk("f_push_pre", 192'(f_res_push), 192'(0));
               chk("f_no_early_push", 192'(early_push), 192'(0));
            end
            61: begin
               chk("f_push_first", 192'(f_res_push), 192'(1));
               chk("f_done_early", 192'(f_done), 192'(0));
               chk("f_pass_hold", 192'(f_pass), 192'(2));
            end
            62: chk("f_push_gap", 192'(f_res_push), 192'(0));
            63: begin
               chk("f_push_last", 192'(f_res_push), 192'(1));
               chk("f_done", 192'(f_done), 192'(1));
               chk("f_pe1_loop", 192'(f_pe[24 +: 24]), 192'(24'h000002));
            end
            64: begin
               chk("f_fsm_start_q", 192'(f_fsm_start), 192'(1));
               chk("f_pending_clr", 192'(f_pending), 192'(0));
               chk("f_ready_q", 192'(f_ready), 192'(0));
               chk("f_input_sel_clr", 192'(f_input_sel), 192'(0));
               chk("f_pass_clr", 192'(f_pass), 192'(0));
               chk("f_done_pulse", 192'(f_done), 192'(0));
`ifdef FIOS_CYCLE_COUNT_EN
               chk("f_cycles_meas", 192'(f_cycles), 192'(t_done - t_start));
               chk("f_cycles", 192'(f_cycles), 192'(62));
`endif
            end
            72: chk("f_overflow_sticky", 192'(f_overflow), 192'(1));
            73: begin
               chk("f_ready_rst", 192'(f_ready), 192'(1));
               chk("f_overflow_rst", 192'(f_overflow), 192'(0));
               chk("f_pending_rst", 192'(f_pending), 192'(0));
               chk("f_pass_rst", 192'(f_pass), 192'(0));
            end
            74: chk("f_flush74", 192'(f_pe), 192'(0));
            78: chk("f_flush78", 192'(f_pe), 192'(0));
            86: chk("f_flush86", 192'(f_pe), 192'(0));
            default: ;
         endcase
      end
      f_start = 1'b0;
      f_seed  = '0;
      rst     = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      do_reset();
      @(negedge clk);
      chk("rst_f_ready", 192'(f_ready), 192'(1));
      chk("rst_f_state", 192'(f_state), 192'(ST_IDLE));
      chk("rst_f_flags", 192'({f_fsm_start, f_pending, f_overflow, f_input_sel}), 192'(0));
      chk("rst_f_outs", 192'({f_a_shift, f_res_push, f_done}), 192'(0));
      chk("rst_f_pass", 192'(f_pass), 192'(0));
      chk("rst_f_pe", 192'(f_pe), 192'(0));
      chk("rst_e_ready", 192'(e_ready), 192'(1));
      chk("rst_e_state", 192'(e_state), 192'(ST_IDLE));
      chk("rst_e_flags", 192'({e_fsm_start, e_pending, e_overflow, e_input_sel, e_a_shift, e_res_push, e_done}), 192'(0));
      chk("rst_e_pe", 192'(e_pe), 192'(0));
`ifdef FIOS_CYCLE_COUNT_EN
      chk("rst_cycles", 192'({f_cycles, e_cycles}), 192'(0));
`endif
      expand_run();
      fold_run();
      // Second run after the mid-run reset must reproduce the same trace.
      fold_run();
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
